// File: rtl/clock_switch_ctrl_if.sv
// Handshake bundle between a clock-source requester and clock_switch_ctrl.
// The master side issues switch requests; the slave side sequences the mux and the gate.
interface clock_switch_ctrl_if;
    logic sw_en;
    logic sel_req;
    logic mux_sel;
    logic clk_en;
    logic busy;
    logic switch_done;

    modport master (
        output sw_en,
        output sel_req,
        input  mux_sel,
        input  clk_en,
        input  busy,
        input  switch_done
    );

    modport slave (
        input  sw_en,
        input  sel_req,
        output mux_sel,
        output clk_en,
        output busy,
        output switch_done
    );
endinterface

// File: rtl/clock_switch_ctrl.sv
// Glitch-free clock source switch sequencer: gate, wait, change mux select, settle, ungate.
// Runs entirely on the always-on reference clock.
module clock_switch_ctrl #(
    parameter int unsigned GATE_WAIT = 4,
    parameter int unsigned SEL_WAIT  = 8
) (
    input  logic          clk,
    input  logic          reset,
    clock_switch_ctrl_if.slave sw
);

    typedef enum logic [1:0] {
        STARTUP  = 2'd0,
        IDLE     = 2'd1,
        GATE_OFF = 2'd2,
        SETTLE   = 2'd3
    } state_t;

    localparam logic [7:0] GATE_LOAD = 8'(GATE_WAIT - 1);
    localparam logic [7:0] SEL_LOAD  = 8'(SEL_WAIT - 1);

    state_t     state, state_d;
    logic [7:0] cnt, cnt_d;
    logic       target, target_d;
    logic       mux_sel_q, mux_sel_d;
    logic       clk_en_q, clk_en_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= STARTUP;
            cnt       <= SEL_LOAD;
            target    <= 1'b0;
            mux_sel_q <= 1'b0;
            clk_en_q  <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            target    <= target_d;
            mux_sel_q <= mux_sel_d;
            clk_en_q  <= clk_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        target_d  = target;
        mux_sel_d = mux_sel_q;
        clk_en_d  = clk_en_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state)
            STARTUP: begin
                if (cnt == '0) begin
                    clk_en_d = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            IDLE: begin
                if (sw.sw_en && (sw.sel_req != mux_sel_q)) begin
                    target_d = sw.sel_req;
                    clk_en_d = 1'b0;
                    busy_d   = 1'b1;
                    cnt_d    = GATE_LOAD;
                    state_d  = GATE_OFF;
                end
            end
            GATE_OFF: begin
                // Output is already gated here, so the mux may change without a visible glitch.
                if (cnt == '0) begin
                    mux_sel_d = target;
                    cnt_d     = SEL_LOAD;
                    state_d   = SETTLE;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    clk_en_d = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            default: begin
                state_d  = STARTUP;
                clk_en_d = 1'b0;
                busy_d   = 1'b1;
                cnt_d    = SEL_LOAD;
            end
        endcase
    end

    assign sw.mux_sel     = mux_sel_q;
    assign sw.clk_en      = clk_en_q;
    assign sw.busy        = busy_q;
    assign sw.switch_done = done_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Self-checking bench for clock_switch_ctrl: directed vectors on a (4,8) instance,
// randomized traffic on (1,1) and (255,3) instances against an elapsed-cycle model.
module tb_clock_switch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_r;

    clock_switch_ctrl_if ia ();
    clock_switch_ctrl_if ib ();
    clock_switch_ctrl_if ic ();

    clock_switch_ctrl #(.GATE_WAIT(4), .SEL_WAIT(8)) dut_a (
        .clk(clk), .reset(rst_a), .sw(ia)
    );
    clock_switch_ctrl #(.GATE_WAIT(1), .SEL_WAIT(1)) dut_b (
        .clk(clk), .reset(rst_r), .sw(ib)
    );
    clock_switch_ctrl #(.GATE_WAIT(255), .SEL_WAIT(3)) dut_c (
        .clk(clk), .reset(rst_r), .sw(ic)
    );

    logic r_en [2];
    logic r_sel[2];
    logic o_mux[2], o_ce[2], o_busy[2], o_done[2];

    assign ib.sw_en   = r_en[0];
    assign ib.sel_req = r_sel[0];
    assign ic.sw_en   = r_en[1];
    assign ic.sel_req = r_sel[1];
    assign o_mux[0]  = ib.mux_sel;
    assign o_ce[0]   = ib.clk_en;
    assign o_busy[0] = ib.busy;
    assign o_done[0] = ib.switch_done;
    assign o_mux[1]  = ic.mux_sel;
    assign o_ce[1]   = ic.clk_en;
    assign o_busy[1] = ic.busy;
    assign o_done[1] = ic.switch_done;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic en;
        logic sel;
        logic e_mux;
        logic e_ce;
        logic e_busy;
        logic e_done;
    } vec_t;
    vec_t tbl[14];

    logic a_prev_ce, a_prev_mux;

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_a(input string name, input logic m, input logic ce, input logic b, input logic d);
        chk({name, ".mux_sel"}, ia.mux_sel, m);
        chk({name, ".clk_en"}, ia.clk_en, ce);
        chk({name, ".busy"}, ia.busy, b);
        chk({name, ".switch_done"}, ia.switch_done, d);
    endtask

    // One reference-clock edge on the directed instance, plus the mux-while-enabled invariant.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (!rst_a) begin
            n_cmp++;
            assert (!(a_prev_ce && (ia.mux_sel !== a_prev_mux))) else begin
                n_bad++;
                $display("FAIL invariant_a: mux_sel changed %b->%b while clk_en=1 (t=%0t)",
                         a_prev_mux, ia.mux_sel, $time);
            end
        end
        a_prev_ce  = ia.clk_en;
        a_prev_mux = ia.mux_sel;
    endtask

    task automatic wait_done(input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            step();
            if (ia.switch_done === 1'b1) seen = 1'b1;
        end
        chk("wait_done", seen, 1'b1);
    endtask

    // Random-phase model: tracks elapsed edges since reset and since request capture.
    int          gw[2];
    int          sw[2];
    int          boot[2], k[2], lowcnt[2];
    bit          up[2], act[2], msel[2], tgt[2], done_e[2], lowtrk[2];
    logic        p_ce[2], p_mux[2];

    initial begin
        gw[0] = 1;   sw[0] = 1;
        gw[1] = 255; sw[1] = 3;

        for (int i = 0; i < 14; i++) begin
            tbl[i].en     = 1'b1;
            tbl[i].sel    = 1'b1;
            tbl[i].e_mux  = (i >= 4);
            tbl[i].e_ce   = (i >= 12);
            tbl[i].e_busy = (i < 12);
            tbl[i].e_done = (i == 12);
        end
        tbl[1].sel = 1'b0;
        tbl[2].sel = 1'b1;
        tbl[3].sel = 1'b0;
        tbl[7].en  = 1'b0;
        tbl[8].en  = 1'b0;

        rst_a = 1'b1;
        rst_r = 1'b1;
        ia.sw_en = 1'b0;
        ia.sel_req = 1'b0;
        for (int d = 0; d < 2; d++) begin
            r_en[d] = 1'b0;
            r_sel[d] = 1'b0;
        end
        a_prev_ce = 1'b0;
        a_prev_mux = 1'b0;

        step();
        step();
        chk_a("reset", 1'b0, 1'b0, 1'b1, 1'b0);

        rst_a = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk_a("startup", 1'b0, (i == 8), (i != 8), 1'b0);
        end

        for (int i = 0; i < 14; i++) begin
            ia.sw_en   = tbl[i].en;
            ia.sel_req = tbl[i].sel;
            step();
            chk_a("table", tbl[i].e_mux, tbl[i].e_ce, tbl[i].e_busy, tbl[i].e_done);
        end

        // Switch 1->0 with request flipped back right after capture: a new switch follows the done pulse.
        for (int i = 0; i < 18; i++) begin
            ia.sw_en   = 1'b1;
            ia.sel_req = (i == 0) ? 1'b0 : 1'b1;
            step();
            chk_a("rerequest", ((i < 4) || (i >= 17)), (i == 12), (i != 12), (i == 12));
        end
        wait_done(40);

        ia.sw_en   = 1'b0;
        ia.sel_req = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            chk_a("sw_en_low", 1'b1, 1'b1, 1'b0, 1'b0);
        end

        ia.sw_en   = 1'b1;
        ia.sel_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_a("noop", 1'b1, 1'b1, 1'b0, 1'b0);
        end

        ia.sel_req = 1'b0;
        wait_done(40);
        ia.sel_req = 1'b1;
        for (int i = 0; i < 6; i++) step();
        @(posedge clk);
        #1;
        chk_a("pre_reset", 1'b1, 1'b0, 1'b1, 1'b0);
        #2 rst_a = 1'b1;
        #1;
        chk_a("async_reset", 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_a = 1'b0;
        ia.sw_en = 1'b0;
        ia.sel_req = 1'b0;
        a_prev_ce = 1'b0;
        a_prev_mux = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk_a("restart", 1'b0, (i == 8), (i != 8), 1'b0);
        end

        for (int d = 0; d < 2; d++) begin
            boot[d] = 0; k[d] = 0; up[d] = 0; act[d] = 0; msel[d] = 0; tgt[d] = 0;
            done_e[d] = 0; lowtrk[d] = 0; lowcnt[d] = 0; p_ce[d] = 1'b0; p_mux[d] = 1'b0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rst_r = (cyc < 2) || ((cyc % 3000) >= 1500 && (cyc % 3000) < 1503);
            for (int d = 0; d < 2; d++) begin
                r_en[d]  = ($urandom_range(0, 3) != 0);
                r_sel[d] = ($urandom_range(0, 7) == 0) ? ~r_sel[d] : r_sel[d];
            end
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                done_e[d] = 0;
                if (rst_r) begin
                    boot[d] = 0; up[d] = 0; act[d] = 0; msel[d] = 0;
                end else if (!up[d]) begin
                    boot[d]++;
                    if (boot[d] == sw[d]) up[d] = 1;
                end else if (act[d]) begin
                    k[d]++;
                    if (k[d] == gw[d]) msel[d] = tgt[d];
                    if (k[d] == gw[d] + sw[d]) begin
                        act[d] = 0;
                        done_e[d] = 1;
                    end
                end else if (r_en[d] && (r_sel[d] != msel[d])) begin
                    act[d] = 1;
                    k[d] = 0;
                    tgt[d] = r_sel[d];
                end
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk(d == 0 ? "rnd11.mux_sel" : "rnd255_3.mux_sel", o_mux[d], msel[d]);
                chk(d == 0 ? "rnd11.clk_en" : "rnd255_3.clk_en", o_ce[d], up[d] && !act[d]);
                chk(d == 0 ? "rnd11.busy" : "rnd255_3.busy", o_busy[d], !(up[d] && !act[d]));
                chk(d == 0 ? "rnd11.switch_done" : "rnd255_3.switch_done", o_done[d], done_e[d]);
                if (!rst_r) begin
                    n_cmp++;
                    assert (!(p_ce[d] && (o_mux[d] !== p_mux[d]))) else begin
                        n_bad++;
                        $display("FAIL invariant_rnd%0d: mux_sel changed %b->%b while clk_en=1 (t=%0t)",
                                 d, p_mux[d], o_mux[d], $time);
                    end
                end
                if (rst_r) begin
                    lowtrk[d] = 0;
                end else if (p_ce[d] && !o_ce[d]) begin
                    lowtrk[d] = 1;
                    lowcnt[d] = 1;
                end else if (lowtrk[d] && !o_ce[d]) begin
                    lowcnt[d]++;
                end else if (lowtrk[d] && o_ce[d]) begin
                    chk_int(d == 0 ? "rnd11.low_window" : "rnd255_3.low_window",
                            lowcnt[d], gw[d] + sw[d]);
                    lowtrk[d] = 0;
                end
                p_ce[d]  = o_ce[d];
                p_mux[d] = o_mux[d];
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_switch_ctrl.md
Name: clock_switch_ctrl

Overview:
Sequencer that switches a two-input clock_mux glitch-free, controlling its select plus a downstream clock-gate enable. Runs on an always-on reference clock, independent of both muxed clocks. Order of operations: gate the output, wait, change select, wait for settling, ungate. Used wherever the PHY changes clock source at runtime, e.g. bypass versus PLL clock.

Parameters:
GATE_WAIT, 4, ref-clock cycles from clk_en falling to mux_sel changing; legal range 1..255
SEL_WAIT, 8, ref-clock cycles from mux_sel changing to clk_en rising; also the startup delay after reset; legal range 1..255

Ports:
clk  input  1  always-on reference clock; all logic is on its rising edge
reset  input  1  asynchronous, active-high reset
sw_en  input  1  switching permitted; sampled only in IDLE
sel_req  input  1  requested mux source, 0 = in0, 1 = in1; level, assumed synchronous to clk
mux_sel  output  1  drives clock_mux sel; registered
clk_en  output  1  enable for the clock gate after the mux; registered, 1 = clock passes
busy  output  1  high in every state except IDLE; registered
switch_done  output  1  one-cycle pulse when a switch completes; registered

Behaviour:
- Reset values (immediate on reset assert): mux_sel=0, clk_en=0, busy=1, switch_done=0, state=STARTUP, cnt=SEL_WAIT-1.
- State register is 2 bits. Down-counter is 8 bits, sized for the max parameter value.
- STARTUP:
  - Decrement cnt each cycle.
  - On the edge where cnt==0: clk_en<=1, busy<=0, state<=IDLE. No switch_done pulse.
  - clk_en therefore rises SEL_WAIT cycles after reset deasserts.
- IDLE:
  - If sw_en==1 and sel_req!=mux_sel at edge N: capture target<=sel_req, clk_en<=0, busy<=1, cnt<=GATE_WAIT-1, state<=GATE_OFF.
  - Otherwise hold all outputs; switch_done<=0.
- GATE_OFF:
  - Decrement cnt each cycle.
  - On the edge where cnt==0: mux_sel<=target, cnt<=SEL_WAIT-1, state<=SETTLE.
  - mux_sel changes at edge N+GATE_WAIT.
- SETTLE:
  - Decrement cnt each cycle.
  - On the edge where cnt==0: clk_en<=1, switch_done<=1, busy<=0, state<=IDLE.
  - clk_en rises at edge N+GATE_WAIT+SEL_WAIT, so clk_en is low for exactly GATE_WAIT+SEL_WAIT cycles.
- switch_done:
  - Goes high on the same edge as clk_en rises.
  - Cleared on the next edge unconditionally.
- Invariant: mux_sel never changes while clk_en==1. The bench checks this with an assertion.
- sel_req changes during GATE_OFF or SETTLE are ignored; target is fixed at request capture.
- If sel_req still differs from mux_sel once back in IDLE:
  - A new switch starts on the first IDLE edge, i.e. the edge after switch_done is asserted.
  - The done pulse still occurs.
- sw_en deasserted mid-switch: ignored, the switch completes. sw_en==0 in IDLE: no switch is started.
- A request with sel_req==mux_sel is a no-op; outputs are unchanged.
- Reset asserted mid-switch:
  - All outputs return to reset values immediately; mux_sel=0 regardless of target.
  - STARTUP sequencing restarts after deassert.
- Unused state encoding: recover to STARTUP, with clk_en=0 and cnt=SEL_WAIT-1.

Test Plan:
- Startup (GATE_WAIT=4, SEL_WAIT=8): release reset at edge 0 -> clk_en=0 and busy=1 through edge 7; clk_en=1 and busy=0 at edge 8; switch_done never pulses; mux_sel=0.
- Single switch: in IDLE, set sw_en=1 and sel_req=1 at edge N -> clk_en=0 from N; mux_sel=1 at N+4; clk_en=1, switch_done=1 and busy=0 at N+12; switch_done=0 at N+13.
- Request churn: toggle sel_req 1->0->1 during GATE_OFF -> exactly one switch to 1, no second switch; a second run with sel_req held 0 after capture -> switch to 1, done pulse, then a new switch back to 0 starting at the next edge.
- Gating: sw_en=0 with sel_req=1 for 50 cycles -> no output change; dropping sw_en mid-SETTLE -> switch still completes at N+12.
- Reset mid-switch: assert reset at N+6 (mux_sel=1, clk_en=0) -> mux_sel=0, clk_en=0, busy=1 immediately, asynchronously; after release, clk_en=1 eight cycles later.
- Random sel_req/sw_en for 10k cycles with parameter sets (1,1) and (255,3) -> assertion holds: no mux_sel change while clk_en=1; every clk_en low window equals GATE_WAIT+SEL_WAIT.
